// File: rtl/disp_pkg.sv
// Shared constants and types for the multiplexed 7-segment display scanner.
// Contents: digit count, nibble and segment widths, and the update FSM state type.
package disp_pkg;

    localparam int unsigned NDIG  = 8;
    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;
    localparam int unsigned DIG_W = $clog2(NDIG);
    localparam int unsigned VAL_W = NDIG * NIB_W;

    // SCAN: idle, accepting updates. PENDING: a value waits for the next frame end.
    typedef enum logic {
        SCAN    = 1'b0,
        PENDING = 1'b1
    } scan_state_e;

endpackage

// File: rtl/disp7segs.sv
// Hex nibble to 7-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
// Ports:
//   nibble - 4-bit value to show (0..F)
//   seg    - segment pattern, bit 0 = a ... bit 6 = g, 0 = segment lit
module disp7segs
    import disp_pkg::*;
(
    input  logic [NIB_W-1:0] nibble,
    output logic [SEG_W-1:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/disp_scan_ctrl.sv
// Eight-digit time-multiplexed 7-segment scanner with a frame-synchronous
// update handshake and optional leading-zero blanking.
// Ports:
//   clk_i      - system clock, rising edge
//   rst_i      - asynchronous active-high reset
//   valor_i    - value to display, nibble k drives digit k
//   valid_i    - update request
//   ready_o    - update can be accepted this cycle
//   blank_lz_i - leading-zero blanking enable (affects an_o only)
//   seg_o      - segment pattern of the currently scanned digit
//   an_o       - one-hot active-low digit enable
//   frame_o    - one-cycle pulse on the last cycle of digit 7
module disp_scan_ctrl
    import disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned GUARD       = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [VAL_W-1:0] valor_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             blank_lz_i,
    output logic [SEG_W-1:0] seg_o,
    output logic [NDIG-1:0]  an_o,
    output logic             frame_o
);

    localparam int unsigned PRE_W = $clog2(REFRESH_DIV);

    logic [PRE_W-1:0] presc_q;
    logic [DIG_W-1:0] digit_q;
    scan_state_e      state_q, state_d;
    logic [VAL_W-1:0] pend_q, pend_d;
    logic [VAL_W-1:0] disp_q, disp_d;
    logic             ready_q;
    logic             frame_q;

    logic             tick;
    logic             last_digit;
    logic             frame_end;
    logic [VAL_W-1:0] disp_shift;
    logic             upper_zero;
    logic [NDIG-1:0]  an_c;

    assign tick       = (presc_q == PRE_W'(REFRESH_DIV - 1));
    assign last_digit = (digit_q == DIG_W'(NDIG - 1));
    assign frame_end  = tick && last_digit;

    // Update handshake: next-state and data-path selection.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        disp_d  = disp_q;
        case (state_q)
            SCAN: begin
                if (valid_i) begin
                    pend_d  = valor_i;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_end) begin
                    disp_d  = pend_q;
                    state_d = SCAN;
                end
            end
            default: state_d = SCAN;
        endcase
    end

    // Counters, handshake state and look-ahead registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            digit_q <= '0;
            state_q <= SCAN;
            pend_q  <= '0;
            disp_q  <= '0;
            ready_q <= 1'b1;
            frame_q <= 1'b0;
        end else begin
            presc_q <= tick ? '0 : presc_q + PRE_W'(1);
            if (tick) begin
                digit_q <= digit_q + DIG_W'(1);
            end
            state_q <= state_d;
            pend_q  <= pend_d;
            disp_q  <= disp_d;
            ready_q <= (state_d == SCAN);
            // Digit does not change before the tick, so one cycle ahead of
            // frame end is the second-to-last prescaler count of digit 7.
            frame_q <= (presc_q == PRE_W'(REFRESH_DIV - 2)) && last_digit;
        end
    end

    assign ready_o = ready_q;
    assign frame_o = frame_q;

    // Current nibble sits at the bottom; anything left above means a non-leading digit.
    assign disp_shift = disp_q >> (32'(digit_q) * NIB_W);
    assign upper_zero = (disp_shift == '0);

    disp7segs u_dec (
        .nibble (disp_shift[NIB_W-1:0]),
        .seg    (seg_o)
    );

    // Anode drive: guard interval first, then the selected digit unless blanked.
    always_comb begin
        an_c = '1;
        if ((presc_q >= PRE_W'(GUARD)) &&
            !(blank_lz_i && (digit_q != '0) && upper_zero)) begin
            an_c = ~(NDIG'(1) << digit_q);
        end
    end

    assign an_o = an_c;

endmodule
